adc_resp_spi: RTL and testbench

Synthesizable SPI responder that emulates the ADC128S 8-channel, 12-bit converter interface. It allows the `adc_spi` master and the effects datapath to be exercised on hardware without the physical ADC. The block oversamples the master's `SCLK`/`SS_n`/`MOSI` with the system clock, decodes the channel address from each 16-bit control frame, and returns the 12-bit sample for the previously addressed channel on `MISO`. Sample values come from a parallel 8-channel input bus, for example a test-tone generator or a register bank.

---
 rtl/adc_resp_spi.sv | 156 +++++++++++++++
 tb/tb_adc_resp_spi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_resp_spi.sv
// adc_resp_spi: SPI responder that emulates an ADC128S-style 8-channel, 12-bit
// converter. SCLK/SS_n/MOSI are oversampled with clk, the channel address is
// decoded from each 16-bit control frame, and the sample of the previously
// addressed channel is shifted out on MISO (CPOL=1, MSB first).
// Build option: define ADC_RESP_TRISTATE_EN to float MISO outside a frame.
module adc_resp_spi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_data,
  output logic [2:0]  cmd_channel,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_q, ss_q;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Only RX[13:11] carries the address; the two bits above it are never needed
  // so the shift register stops at bit 13.
  logic [13:0] rx_shift;
  logic [15:0] tx_shift;
  logic [15:0] tx_snap;
  logic [4:0]  rise_cnt, fall_cnt;
  logic [3:0]  tx_idx;
  logic [2:0]  pending_ch;
  logic        miso_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise =  sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s &  sclk_q;
  assign ss_rise   =  ss_s   & ~ss_q;
  assign ss_fall   = ~ss_s   &  ss_q;

  assign tx_snap = {4'b0000, ch_data[12*pending_ch +: 12]};
  // For fall counts 1..15 this is 16 - fall_cnt, i.e. TX bit (17 - k) for fall k.
  assign tx_idx  = 4'd0 - fall_cnt[3:0];

  // Input synchronizers plus one edge-detect stage; SS_n resets low so a frame
  // already running at reset release can never look like a fresh SS_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b1;
      ss_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: SS_n strobes drive every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (ss_s)    state_nxt = IDLE;
      IDLE:      if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:    if (ss_rise) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // Frame datapath: snapshot, shifting, counting and end-of-frame decode;
  // an SS_n strobe always wins over an SCLK strobe in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      rise_cnt    <= '0;
      fall_cnt    <= '0;
      pending_ch  <= '0;
      cmd_channel <= '0;
      miso_q      <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shift <= tx_snap;
            rise_cnt <= '0;
            fall_cnt <= '0;
            miso_q   <= tx_snap[15];
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            miso_q <= 1'b0;
            if (rise_cnt == 5'd16) begin
              pending_ch  <= rx_shift[13:11];
              cmd_channel <= rx_shift[13:11];
              frame_done  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise && rise_cnt != 5'd16) begin
              rx_shift <= {rx_shift[12:0], mosi_s};
              rise_cnt <= rise_cnt + 5'd1;
            end
            if (sclk_fall) begin
              if (fall_cnt != 5'd16) fall_cnt <= fall_cnt + 5'd1;
              if (fall_cnt == 5'd0)       miso_q <= tx_shift[15];
              else if (fall_cnt == 5'd16) miso_q <= 1'b0;
              else                        miso_q <= tx_shift[tx_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state: busy while ACTIVE, MISO released otherwise.
  always_comb begin
    busy = (state == ACTIVE);
`ifdef ADC_RESP_TRISTATE_EN
    MISO = (state == ACTIVE) ? miso_q : 1'bz;
`else
    MISO = (state == ACTIVE) ? miso_q : 1'b0;
`endif
  end

endmodule

// File: tb/tb_adc_resp_spi.sv
// tb_adc_resp_spi: drives CPOL=1 SPI frames into adc_resp_spi and checks MISO
// data, channel decode, frame pulses and reset recovery against a frame-level
// reference model of the responder.
module tb_adc_resp_spi;

  localparam int PH = 10;
`ifdef ADC_RESP_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] ch_data = '0;
  logic [2:0]  cmd_channel;
  logic        frame_done, frame_err, busy;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [2:0] cmd_at_done = '0;

  // Reference model state: channel whose data the next frame returns, and the
  // last committed command channel.
  logic [2:0] m_pending = '0;
  logic [2:0] m_cmd = '0;

  adc_resp_spi #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .ch_data(ch_data), .cmd_channel(cmd_channel),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Count frame pulses and capture cmd_channel in the cycle frame_done is high.
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      cmd_at_done = cmd_channel;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One frame of n SCLK cycles; MISO is sampled just before each rise, which is
  // where the master samples it.
  task automatic applyStimulus(input string tag, input logic [15:0] mw, input int n,
                               input logic chg, input logic [11:0] mid_val);
    logic [15:0] tx, got, expw, mask;
    int d0, e0;
    tx = {4'b0000, 12'(ch_data >> (12 * m_pending))};
    d0 = done_cnt;
    e0 = err_cnt;
    got = '0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (PH) @(negedge clk);
    checkOutput({tag, "/busy"}, {15'b0, busy}, 16'h0001);
    checkOutput({tag, "/first"}, {15'b0, MISO}, {15'b0, tx[15]});
    for (int k = 1; k <= n; k++) begin
      SCLK = 1'b0;
      MOSI = mw[16-k];
      if (chg && k == 8) ch_data[12*m_pending +: 12] = mid_val;
      repeat (PH) @(negedge clk);
      got[16-k] = MISO;
      SCLK = 1'b1;
      repeat (PH) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (PH) @(negedge clk);
    // Fall 1 re-presents bit 15, fall k>=2 presents bit 17-k.
    expw = (tx >> 1) | (tx & 16'h8000);
    mask = 16'hFFFF << (16 - n);
    checkOutput({tag, "/word"}, got & mask, expw & mask);
    if (n == 16) begin
      m_pending = mw[13:11];
      m_cmd = mw[13:11];
    end
    checkOutput({tag, "/done"}, 16'(done_cnt - d0), (n == 16) ? 16'd1 : 16'd0);
    checkOutput({tag, "/err"}, 16'(err_cnt - e0), (n == 16) ? 16'd0 : 16'd1);
    checkOutput({tag, "/cmd"}, {13'b0, cmd_channel}, {13'b0, m_cmd});
    if (n == 16) checkOutput({tag, "/cmdAtDone"}, {13'b0, cmd_at_done}, {13'b0, m_cmd});
    checkOutput({tag, "/busyIdle"}, {15'b0, busy}, 16'h0000);
    checkOutput({tag, "/misoIdle"}, {15'b0, MISO}, {15'b0, IDLE_MISO});
  endtask

  initial begin
    logic [15:0] w;
    int n, d0, e0;
    logic busy_or, miso_ok;

    // Reset values.
    repeat (5) @(negedge clk);
    checkOutput("rst/miso", {15'b0, MISO}, {15'b0, IDLE_MISO});
    checkOutput("rst/cmd", {13'b0, cmd_channel}, 16'h0000);
    checkOutput("rst/done", {15'b0, frame_done}, 16'h0000);
    checkOutput("rst/err", {15'b0, frame_err}, 16'h0000);
    checkOutput("rst/busy", {15'b0, busy}, 16'h0000);
    rst_n = 1'b1;
    repeat (PH) @(negedge clk);

    // First frame returns channel 0 and addresses channel 1.
    ch_data[11:0] = 12'hA5C;
    applyStimulus("f1", 16'h0800, 16, 1'b0, 12'h0);
    // Second frame returns channel 1 and addresses channel 3.
    ch_data[23:12] = 12'h123;
    applyStimulus("f2", 16'h1800, 16, 1'b0, 12'h0);
    // Aborted frame to channel 5 after 9 cycles leaves channel 3 pending.
    ch_data[47:36] = 12'h9B7;
    applyStimulus("abort", 16'h2800, 9, 1'b0, 12'h0);
    applyStimulus("afterAbort", 16'h0000, 16, 1'b0, 12'h0);
    // Mid-frame data change affects only the following frame.
    ch_data[11:0] = 12'h111;
    applyStimulus("midChg", 16'h0000, 16, 1'b1, 12'h222);
    applyStimulus("afterChg", 16'h0000, 16, 1'b0, 12'h0);

    // Randomized frames, occasionally cut short.
    for (int i = 0; i < 10; i++) begin
      ch_data = {$urandom, $urandom, $urandom};
      w = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      applyStimulus($sformatf("rnd%0d", i), w, n, 1'b0, 12'h0);
    end
    applyStimulus("toCh7", 16'h3800, 16, 1'b0, 12'h0);

    // Reset in the middle of a frame, released while SS_n is still low.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (PH) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      SCLK = 1'b0; repeat (PH) @(negedge clk);
      SCLK = 1'b1; repeat (PH) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (PH) @(negedge clk);
    rst_n = 1'b1;
    m_pending = '0;
    m_cmd = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    busy_or = 1'b0;
    miso_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      SCLK = 1'b0;
      MOSI = k[0];
      repeat (PH) @(negedge clk);
      busy_or = busy_or | busy;
      miso_ok = miso_ok & (MISO === IDLE_MISO);
      SCLK = 1'b1;
      repeat (PH) @(negedge clk);
      busy_or = busy_or | busy;
      miso_ok = miso_ok & (MISO === IDLE_MISO);
    end
    SS_n = 1'b1;
    repeat (PH) @(negedge clk);
    checkOutput("rstMid/done", 16'(done_cnt - d0), 16'd0);
    checkOutput("rstMid/err", 16'(err_cnt - e0), 16'd0);
    checkOutput("rstMid/busy", {15'b0, busy_or}, 16'h0000);
    checkOutput("rstMid/miso", {15'b0, miso_ok}, 16'h0001);
    checkOutput("rstMid/cmd", {13'b0, cmd_channel}, 16'h0000);
    ch_data[11:0] = 12'h5E1;
    applyStimulus("postRst", 16'h2000, 16, 1'b0, 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
